control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// control_sequencer
// Hardwired control unit for a simple bus-based datapath. A Moore FSM walks
// each instruction through fetch (T0-T2), operand dispatch (T3) and execute /
// writeback (T4-T6). Every control output is decoded from the registered state
// plus the IR contents, so outputs change only after a clock edge (or when the
// datapath reloads ir).
//
// Ports
//   clk          in   system clock, rising edge
//   clr          in   synchronous active-high reset (priority over run)
//   run          in   level request to fetch/execute; sampled in IDLE and at
//                     the final step of each instruction
//   ir[31:0]     in   IR contents: opcode [31:27], Ra [26:23], Rb [22:19],
//                     Rc [18:15]; valid from T3 onward
//   pc_out .. lo_in   out  1-bit datapath strobes
//   reg_in[15:0] out  one-hot register-file write enables (bit n -> Rn)
//   reg_out[15:0]out  one-hot register-file read enables (bit n -> Rn)
//   op_code[4:0] out  ALU operation select (driven in T4)
//   busy         out  state is neither IDLE nor HALT
//   halted       out  state is HALT
//   instr_done   out  one-cycle pulse in the final step of an instruction
//   illegal      out  sticky flag, set by an undecodable opcode
//   instr_count  out  completed-instruction counter, wraps at 16 bits

module control_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic [31:0] ir,
  output logic        pc_out,
  output logic        pc_in,
  output logic        pc_increment,
  output logic        mar_in,
  output logic        read,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        ir_in,
  output logic        y_in,
  output logic        zlow_in,
  output logic        zhigh_in,
  output logic        zlow_out,
  output logic        zhigh_out,
  output logic        hi_in,
  output logic        lo_in,
  output logic [15:0] reg_in,
  output logic [15:0] reg_out,
  output logic [4:0]  op_code,
  output logic        busy,
  output logic        halted,
  output logic        instr_done,
  output logic        illegal,
  output logic [15:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  localparam logic [4:0] OP_RTYPE_MAX = 5'b01100;
  localparam logic [4:0] OP_MUL       = 5'b01111;
  localparam logic [4:0] OP_DIV       = 5'b10000;
  localparam logic [4:0] OP_NOP       = 5'b11010;
  localparam logic [4:0] OP_HALT      = 5'b11011;

  state_t      r_state;
  logic        r_illegal;
  logic [15:0] r_instr_count;

  // IR field decode
  logic [4:0]  w_opcode;
  logic [3:0]  w_ra;
  logic [3:0]  w_rb;
  logic [3:0]  w_rc;
  logic        w_op_rtype;
  logic        w_op_muldiv;
  logic        w_op_nop;
  logic        w_op_halt;
  logic        w_op_illegal;
  logic [15:0] w_ra_sel;
  logic [15:0] w_rb_sel;
  logic [15:0] w_rc_sel;
  logic        w_instr_done;

  assign w_opcode     = ir[31:27];
  assign w_ra         = ir[26:23];
  assign w_rb         = ir[22:19];
  assign w_rc         = ir[18:15];
  assign w_op_rtype   = (w_opcode <= OP_RTYPE_MAX);
  assign w_op_muldiv  = (w_opcode == OP_MUL) || (w_opcode == OP_DIV);
  assign w_op_nop     = (w_opcode == OP_NOP);
  assign w_op_halt    = (w_opcode == OP_HALT);
  assign w_op_illegal = !(w_op_rtype || w_op_muldiv || w_op_nop || w_op_halt);

  assign w_ra_sel = 16'h0001 << w_ra;
  assign w_rb_sel = 16'h0001 << w_rb;
  assign w_rc_sel = 16'h0001 << w_rc;

  // Final step: T3 for anything without an execute phase, T5 for R-type,
  // T6 for MUL/DIV. T5 of a non-MUL/DIV opcode also ends the instruction so a
  // datapath that disturbs ir mid-instruction cannot wedge the sequencer.
  assign w_instr_done = ((r_state == S_T3) && !(w_op_rtype || w_op_muldiv)) ||
                        ((r_state == S_T5) && !w_op_muldiv) ||
                        (r_state == S_T6);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state       <= S_IDLE;
      r_illegal     <= 1'b0;
      r_instr_count <= 16'h0000;
    end else begin
      if (w_instr_done) begin
        r_instr_count <= r_instr_count + 16'd1;
      end
      if ((r_state == S_T3) && w_op_illegal) begin
        r_illegal <= 1'b1;
      end
      case (r_state)
        S_IDLE: if (run) r_state <= S_T0;
        S_T0:   r_state <= S_T1;
        S_T1:   r_state <= S_T2;
        S_T2:   r_state <= S_T3;
        S_T3: begin
          if (w_op_rtype || w_op_muldiv) r_state <= S_T4;
          else if (w_op_halt)            r_state <= S_HALT;
          else                           r_state <= run ? S_T0 : S_IDLE;
        end
        S_T4:   r_state <= S_T5;
        S_T5: begin
          if (w_op_muldiv) r_state <= S_T6;
          else             r_state <= run ? S_T0 : S_IDLE;
        end
        S_T6:   r_state <= run ? S_T0 : S_IDLE;
        S_HALT: r_state <= S_HALT;  // only clr leaves HALT
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    pc_out       = 1'b0;
    pc_in        = 1'b0;
    pc_increment = 1'b0;
    mar_in       = 1'b0;
    read         = 1'b0;
    mdr_in       = 1'b0;
    mdr_out      = 1'b0;
    ir_in        = 1'b0;
    y_in         = 1'b0;
    zlow_in      = 1'b0;
    zhigh_in     = 1'b0;
    zlow_out     = 1'b0;
    zhigh_out    = 1'b0;
    hi_in        = 1'b0;
    lo_in        = 1'b0;
    reg_in       = 16'h0000;
    reg_out      = 16'h0000;
    op_code      = 5'b00000;
    case (r_state)
      S_T0: begin
        pc_out       = 1'b1;
        pc_increment = 1'b1;
        mar_in       = 1'b1;
        zlow_in      = 1'b1;
        zhigh_in     = 1'b1;
      end
      S_T1: begin
        zlow_out = 1'b1;
        pc_in    = 1'b1;
        read     = 1'b1;
        mdr_in   = 1'b1;
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      S_T3: begin
        // First operand goes to Y: Rb for R-type, Ra for MUL/DIV.
        if (w_op_rtype) begin
          reg_out = w_rb_sel;
          y_in    = 1'b1;
        end else if (w_op_muldiv) begin
          reg_out = w_ra_sel;
          y_in    = 1'b1;
        end
      end
      S_T4: begin
        op_code  = w_opcode;
        zlow_in  = 1'b1;
        zhigh_in = 1'b1;
        if (w_op_rtype)       reg_out = w_rc_sel;
        else if (w_op_muldiv) reg_out = w_rb_sel;
      end
      S_T5: begin
        zlow_out = 1'b1;
        if (w_op_muldiv)     lo_in  = 1'b1;
        else if (w_op_rtype) reg_in = w_ra_sel;
      end
      S_T6: begin
        zhigh_out = 1'b1;
        hi_in     = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy        = (r_state != S_IDLE) && (r_state != S_HALT);
  assign halted      = (r_state == S_HALT);
  assign instr_done  = w_instr_done;
  assign illegal     = r_illegal;
  assign instr_count = r_instr_count;

endmodule
